// File: rtl/irq_ctrl_if.sv
// CPU-side bus for irq_ctrl: address/data strobe in, read data and window select out.
interface irq_ctrl_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    logic        bus_en;
    logic [7:0]  rdata;
    logic        sel;

    modport master (output addr, wdata, rw, bus_en, input rdata, sel);
    modport slave  (input addr, wdata, rw, bus_en, output rdata, sel);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller for the 6502 bus.
// Synchronises NSRC request lines plus one NMI request, keeps edge/level
// pending bits, drives a registered irq and a fixed-length nmi pulse.
module irq_ctrl #(
    parameter int          NSRC      = 8,
    parameter logic [15:0] BASE      = 16'h4000,
    parameter int          NMI_PULSE = 4
) (
    input  logic            clk,
    input  logic            reset,
    irq_ctrl_if.slave       bus,
    input  logic [NSRC-1:0] src,
    input  logic            nmi_src,
    output logic            irq,
    output logic            nmi
);
    // 17-bit compare so a window near the top of memory cannot wrap
    localparam logic [16:0] WIN_LO = {1'b0, BASE};
    localparam logic [16:0] WIN_HI = WIN_LO + 17'd4;

    typedef enum logic {IDLE, PULSE} nmi_state_t;

    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] sedge, clr, pm;
    logic [NSRC-1:0] pend, mask, mode;
    logic            n1, n2, n3, nedge;
    logic            nmi_en;
    logic [2:0]      off;
    logic            wr;
    logic [7:0]      pend8, mask8, mode8, vec;
    nmi_state_t      state, state_next;
    logic [7:0]      cnt, cnt_next;
    logic            nmi_next;

    assign bus.sel = ({1'b0, bus.addr} >= WIN_LO) && ({1'b0, bus.addr} <= WIN_HI);
    assign off     = 3'(bus.addr - BASE);
    assign wr      = bus.bus_en && !bus.rw && bus.sel;
    assign sedge   = s2 & ~s3;
    assign nedge   = n2 & ~n3;
    assign clr     = (wr && off == 3'd0) ? bus.wdata[NSRC-1:0] : '0;
    assign pm      = pend & mask;

    // two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0; s2 <= '0; s3 <= '0;
            n1 <= 1'b0; n2 <= 1'b0; n3 <= 1'b0;
        end else begin
            s1 <= src;     s2 <= s1; s3 <= s2;
            n1 <= nmi_src; n2 <= n1; n3 <= n2;
        end
    end

    // edge bits latch until W1C (a same-cycle edge beats the clear); level bits track s2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend <= '0;
        else        pend <= (mode & ((pend & ~clr) | sedge)) | (~mode & s2);
    end

    // config registers and the registered irq output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask   <= '0;
            mode   <= '0;
            nmi_en <= 1'b1;
            irq    <= 1'b0;
        end else begin
            irq <= |pm;
            if (wr) begin
                case (off)
                    3'd1:    mask   <= bus.wdata[NSRC-1:0];
                    3'd2:    mode   <= bus.wdata[NSRC-1:0];
                    3'd4:    nmi_en <= bus.wdata[0];
                    default: ;
                endcase
            end
        end
    end

    // NMI FSM state, counter and output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            nmi   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            nmi   <= nmi_next;
        end
    end

    // NMI next state: load the pulse length from IDLE only, count down while pulsing
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        nmi_next   = nmi;
        case (state)
            IDLE: if (nedge && nmi_en) begin
                state_next = PULSE;
                cnt_next   = 8'(NMI_PULSE);
                nmi_next   = 1'b1;
            end
            PULSE: if (cnt == 8'd1) begin
                state_next = IDLE;
                cnt_next   = '0;
                nmi_next   = 1'b0;
            end else begin
                cnt_next   = cnt - 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    // priority vector: lowest-numbered pending & unmasked source wins
    always_comb begin
        vec = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (pm[i]) vec = {1'b1, 4'b0, 3'(i)};
    end

    // read mux; side-effect free, forced to zero while reset is asserted
    always_comb begin
        pend8 = '0; pend8[NSRC-1:0] = pend;
        mask8 = '0; mask8[NSRC-1:0] = mask;
        mode8 = '0; mode8[NSRC-1:0] = mode;
        bus.rdata = '0;
        if (bus.sel && reset) begin
            case (off)
                3'd0:    bus.rdata = pend8;
                3'd1:    bus.rdata = mask8;
                3'd2:    bus.rdata = mode8;
                3'd3:    bus.rdata = vec;
                3'd4:    bus.rdata = {7'b0, nmi_en};
                default: bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller that schedules up to NSRC peripheral interrupt sources onto the single irq input of cpu6502, and produces a timed nmi pulse.
- Sits on the CPU address/data bus beside the ROM/RAM decoders.
- Firmware masks sources, selects edge or level mode per source, reads a priority vector and acknowledges with write-1-to-clear.

Parameters:
- NSRC, 8: number of maskable sources (1..8); unused register bits read 0.
- BASE, 16'h4000: base address of the 5-byte register window.
- NMI_PULSE, 4: nmi output high time in clk cycles (1..255).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  16  CPU address bus.
- wdata  input  8  CPU write data (cpu odata).
- rw  input  1  1 = read, 0 = write.
- bus_en  input  1  one-cycle access strobe; writes commit only when high.
- rdata  output  8  read data; 8'h00 when not selected.
- sel  output  1  high when addr is in [BASE, BASE+4]; drives the read-data mux.
- src  input  NSRC  asynchronous interrupt request lines, active-high.
- nmi_src  input  1  asynchronous NMI request, active-high.
- irq  output  1  registered, active-high, to cpu irq.
- nmi  output  1  registered, active-high pulse, to cpu nmi.

Behaviour:
- Register map (offset from BASE):
  - +0 PEND: R pending bits; W write-1-to-clear, edge-mode bits only.
  - +1 MASK: R/W, reset 8'h00.
  - +2 MODE: R/W; 1 = edge, 0 = level; reset 8'h00.
  - +3 VEC: R only; {any, 4'b0, idx[2:0]}. idx is the lowest-numbered set bit of PEND&MASK; VEC = 8'h00 when PEND&MASK is empty.
  - +4 NMICFG: R/W bit0 = NMI enable, reset 1; other bits read 0.
- Reset (reset==0, asynchronous):
  - All flops clear.
  - irq=0, nmi=0, rdata=0; MASK, MODE and PEND = 0; NMICFG = 1; NMI counter = 0.
  - Takes effect immediately, even mid-pulse or mid-access.
- Synchronisers: each src bit and nmi_src pass through two flops (s1, s2). An edge is s2 & ~s3, using a third history flop.
- Edge-mode PEND bit:
  - Set on a synchronised rising edge.
  - Cleared by a write to +0 with that bit = 1.
  - If set and clear occur in the same cycle, set wins.
- Level-mode PEND bit: equals s2 each cycle; W1C has no effect.
- Changing a bit in MODE takes effect the next cycle. Switching edge→level replaces the latched bit with the level.
- irq register = |(PEND & MASK), updated every cycle.
- Latency: src rises before edge 0; s1 at edge 0, s2 at edge 1, PEND at edge 2, irq at edge 3. Masking or acknowledging drops irq one cycle after the write edge.
- Reads:
  - rdata is combinational from addr while sel==1, independent of bus_en.
  - Reads have no side effects.
  - Offsets outside +0..+4 never select.
- Writes: commit on the rising edge where bus_en==1 && rw==0 && sel==1. Writes to VEC are ignored.
- NMI FSM, states IDLE and PULSE:
  - IDLE → PULSE on a synchronised nmi_src rising edge while NMICFG[0]==1. The counter loads NMI_PULSE and nmi goes high on the same edge.
  - In PULSE the counter decrements each cycle; at 1 it returns to IDLE and nmi goes low. nmi is high for exactly NMI_PULSE cycles.
  - nmi_src edges during PULSE are ignored (no retrigger, not queued).
  - Clearing NMICFG[0] during PULSE does not truncate the pulse.
- Counter width is 8 bits; no wrap occurs because it is only loaded from IDLE.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release. Read +0..+4 → 00, 00, 00, 00, 01; irq=0, nmi=0.
- Edge IRQ: write MODE=8'h04, MASK=8'h04; pulse src[2] high 1 cycle (after sync settles). irq=1 exactly 3 edges after sampling, PEND=8'h04, VEC=8'h82. Write 8'h04 to +0 → irq=0 next cycle, PEND=8'h00.
- Priority / level: MODE=8'h00, MASK=8'hFF; hold src=8'h60 → VEC=8'h85. Drop src[5] → VEC=8'h86. Drop all → irq=0, VEC=8'h00. W1C to a level bit leaves PEND=src.
- Mask: MASK=8'h00, src[0] edge-mode pulse → PEND=8'h01, irq stays 0. Write MASK=8'h01 → irq=1 one cycle later.
- Set/clear collision: in the same cycle as a synchronised edge on src[1], write 8'h02 to +0 → PEND[1] stays 1.
- NMI: nmi_src rises → nmi high for 4 cycles. A second edge during the pulse → no extension. NMICFG=0 → no pulse. Assert reset mid-pulse → nmi=0 immediately.
